// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StGuard
  } arb_state_e;

  localparam logic REQ_INERT = 1'b0;
  localparam logic REQ_A2D   = 1'b1;

endpackage

// File: rtl/spi_arb_if.sv
// Requester-side and SPI-master-side signals of the arbiter.
interface spi_arb_if;
  logic        wrt0;
  logic        wrt1;
  logic [15:0] cmd0;
  logic [15:0] cmd1;
  logic        done0;
  logic        done1;
  logic [15:0] rd_data;
  logic        busy0;
  logic        busy1;
  logic        ovr0;
  logic        ovr1;
  logic        m_wrt;
  logic [15:0] m_cmd;
  logic        m_done;
  logic [15:0] m_rd_data;
  logic        owner;

  // Arbiter view.
  modport slave (
    input  wrt0, wrt1, cmd0, cmd1, m_done, m_rd_data,
    output done0, done1, rd_data, busy0, busy1, ovr0, ovr1, m_wrt, m_cmd, owner
  );

  // Environment view: the two requesters plus the SPI master.
  modport master (
    output wrt0, wrt1, cmd0, cmd1, m_done, m_rd_data,
    input  done0, done1, rd_data, busy0, busy1, ovr0, ovr1, m_wrt, m_cmd, owner
  );
endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between the inertial (0) and A2D (1) requesters.
// Buffers one command per requester and routes done/read data back to the bus owner.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned GUARD = 4
) (
  input logic      clk,
  input logic      rst_n,
  spi_arb_if.slave bus
);

  localparam int unsigned CntW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  arb_state_e       state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       ovr_q, ovr_d;
  logic [1:0]       done_q, done_d;
  logic [1:0][15:0] buf_q, buf_d;
  logic [1:0][15:0] cmd;
  logic [1:0]       wrt;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             winner;
  logic [15:0]      m_cmd_q, m_cmd_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             active;

  assign wrt = {bus.wrt1, bus.wrt0};
  assign cmd = {bus.cmd1, bus.cmd0};

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    done_d    = 2'b00;
    buf_d     = buf_q;
    last_d    = last_q;
    owner_d   = owner_q;
    m_cmd_d   = m_cmd_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    winner    = REQ_INERT;

    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          winner        = (&pend_q) ? ~last_q : pend_q[1];
          owner_d       = winner;
          m_cmd_d       = buf_q[winner];
          last_d        = winner;
          pend_d[winner] = 1'b0;
          state_d       = StIssue;
        end
      end
      StIssue: state_d = StBusy;
      StBusy: begin
        if (bus.m_done) begin
          rd_data_d       = bus.m_rd_data;
          done_d[owner_q] = 1'b1;
          if (GUARD == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGuard;
            cnt_d   = CntW'(GUARD);
          end
        end
      end
      StGuard: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // A new strobe wins over a grant clearing the same pending bit; it only counts as an
    // overwrite if the previous command is still unissued.
    for (int n = 0; n < 2; n++) begin
      if (wrt[n]) begin
        if (pend_d[n]) ovr_d[n] = 1'b1;
        pend_d[n] = 1'b1;
        buf_d[n]  = cmd[n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pend_q    <= 2'b00;
      ovr_q     <= 2'b00;
      done_q    <= 2'b00;
      buf_q     <= '0;
      last_q    <= REQ_A2D;
      owner_q   <= REQ_INERT;
      m_cmd_q   <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      done_q    <= done_d;
      buf_q     <= buf_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      m_cmd_q   <= m_cmd_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign active = (state_q == StIssue) || (state_q == StBusy);

  assign bus.m_wrt   = (state_q == StIssue);
  assign bus.m_cmd   = m_cmd_q;
  assign bus.owner   = owner_q;
  assign bus.rd_data = rd_data_q;
  assign bus.done0   = done_q[0];
  assign bus.done1   = done_q[1];
  assign bus.ovr0    = ovr_q[0];
  assign bus.ovr1    = ovr_q[1];
  assign bus.busy0   = pend_q[0] | (active & (owner_q == REQ_INERT));
  assign bus.busy1   = pend_q[1] | (active & (owner_q == REQ_A2D));

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios plus a randomized run against a
// timestamp-based transaction model.
module tb_spi_arb;

  localparam int unsigned G = 4;

  logic clk;
  logic rst_n;
  spi_arb_if bus ();

  spi_arb #(.GUARD(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: pending commands, round-robin pointer and bus-availability timestamps.
  logic [1:0]  m_p;
  logic [15:0] m_b [2];
  logic        m_last;
  logic        m_infl;
  int          m_iss;
  int          m_free;
  logic        e_mwrt;
  logic [15:0] e_cmd;
  logic        e_own;
  logic [1:0]  e_done;
  logic [15:0] e_rd;
  logic [1:0]  e_ovr;

  function automatic logic [39:0] outs();
    return {bus.m_wrt, bus.m_cmd, bus.owner, bus.done0, bus.done1, bus.rd_data,
            bus.busy0, bus.busy1, bus.ovr0, bus.ovr1};
  endfunction

  function automatic logic [39:0] model_outs();
    logic b0, b1;
    b0 = m_p[0] | (m_infl & (e_own == 1'b0));
    b1 = m_p[1] | (m_infl & (e_own == 1'b1));
    return {e_mwrt, e_cmd, e_own, e_done[0], e_done[1], e_rd, b0, b1, e_ovr[0], e_ovr[1]};
  endfunction

  task automatic model_reset();
    m_p    = 2'b00;
    m_b[0] = '0;
    m_b[1] = '0;
    m_last = 1'b1;
    m_infl = 1'b0;
    m_iss  = 0;
    m_free = 0;
    e_mwrt = 1'b0;
    e_cmd  = '0;
    e_own  = 1'b0;
    e_done = 2'b00;
    e_rd   = '0;
    e_ovr  = 2'b00;
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model, move to the
  // next falling edge.
  task automatic tick(input logic w0, input logic [15:0] c0, input logic w1,
                      input logic [15:0] c1, input logic md, input logic [15:0] mrd);
    logic g, acc, win;
    bus.wrt0 = w0;
    bus.cmd0 = c0;
    bus.wrt1 = w1;
    bus.cmd1 = c1;
    bus.m_done = md;
    bus.m_rd_data = mrd;
    g   = 1'b0;
    win = 1'b0;
    if (!m_infl && cyc >= m_free && (m_p != 2'b00)) begin
      g   = 1'b1;
      win = (m_p == 2'b11) ? ~m_last : m_p[1];
    end
    acc    = m_infl && md && (cyc > m_iss);
    e_mwrt = g;
    e_done = 2'b00;
    if (acc) begin
      e_done[e_own] = 1'b1;
      e_rd   = mrd;
      m_infl = 1'b0;
      m_free = cyc + G + 2;
    end
    if (g) begin
      e_own    = win;
      e_cmd    = m_b[win];
      m_last   = win;
      m_infl   = 1'b1;
      m_iss    = cyc + 1;
      m_p[win] = 1'b0;
    end
    if (w0) begin
      if (m_p[0]) e_ovr[0] = 1'b1;
      m_p[0] = 1'b1;
      m_b[0] = c0;
    end
    if (w1) begin
      if (m_p[1]) e_ovr[1] = 1'b1;
      m_p[1] = 1'b1;
      m_b[1] = c1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.wrt0 = 1'b0; bus.wrt1 = 1'b0; bus.cmd0 = '0; bus.cmd1 = '0;
    bus.m_done = 1'b0; bus.m_rd_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wrt0 = 1'b0; bus.wrt1 = 1'b0; bus.cmd0 = '0; bus.cmd1 = '0;
    bus.m_done = 1'b0; bus.m_rd_data = '0;
    #3;
    n_tests++;
    if (outs() !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_during: got %h expected %h", outs(), 40'h0);
    end
    apply_reset();
    idle(2);
    n_tests++;
    if (outs() !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_after: got %h expected %h", outs(), 40'h0);
    end
  endtask

  task automatic test_single();
    int n_d1;
    apply_reset();
    tick(1'b1, 16'hA5A5, 1'b0, 16'h0, 1'b0, 16'h0);
    n_tests++;
    if (bus.m_wrt !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_mwrt: got %b expected 0", bus.m_wrt);
    end
    idle(1);
    n_tests++;
    if ({bus.m_wrt, bus.m_cmd, bus.owner, bus.busy0} !== {1'b1, 16'hA5A5, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_issue: got %b/%h/%b/%b expected 1/a5a5/0/1",
               bus.m_wrt, bus.m_cmd, bus.owner, bus.busy0);
    end
    n_d1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done0 !== 1'b0 || bus.done1 !== 1'b0) n_d1++;
      tick(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    end
    tick(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h1234);
    n_tests++;
    if ({bus.done0, bus.done1, bus.rd_data, bus.busy0} !== {1'b1, 1'b0, 16'h1234, 1'b0}
        || n_d1 != 0) begin
      n_fail++;
      $display("FAIL single_done: got %b/%b/%h/%b early=%0d expected 1/0/1234/0 early=0",
               bus.done0, bus.done1, bus.rd_data, bus.busy0, n_d1);
    end
    idle(1);
    n_tests++;
    if ({bus.done0, bus.rd_data} !== {1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL single_hold: got %b/%h expected 0/1234", bus.done0, bus.rd_data);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    apply_reset();
    tick(1'b1, 16'h0101, 1'b1, 16'h0202, 1'b0, 16'h0);
    idle(1);
    n_tests++;
    if ({bus.m_wrt, bus.owner, bus.m_cmd} !== {1'b1, 1'b0, 16'h0101}) begin
      n_fail++;
      $display("FAIL simul_first: got %b/%b/%h expected 1/0/0101",
               bus.m_wrt, bus.owner, bus.m_cmd);
    end
    idle(3);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0F0F);
    n_tests++;
    if ({bus.done0, bus.done1, bus.rd_data} !== {1'b1, 1'b0, 16'h0F0F}) begin
      n_fail++;
      $display("FAIL simul_done0: got %b/%b/%h expected 1/0/0f0f",
               bus.done0, bus.done1, bus.rd_data);
    end
    k = 1;
    while (bus.m_wrt !== 1'b1 && k < 40) begin
      idle(1);
      k++;
    end
    n_tests++;
    if (k != G + 3 || {bus.owner, bus.m_cmd} !== {1'b1, 16'h0202}) begin
      n_fail++;
      $display("FAIL simul_second: gap %0d owner %b cmd %h, expected gap %0d owner 1 cmd 0202",
               k, bus.owner, bus.m_cmd, G + 3);
    end
    idle(2);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h3C3C);
    n_tests++;
    if ({bus.done0, bus.done1, bus.rd_data} !== {1'b0, 1'b1, 16'h3C3C}) begin
      n_fail++;
      $display("FAIL simul_done1: got %b/%b/%h expected 0/1/3c3c",
               bus.done0, bus.done1, bus.rd_data);
    end
  endtask

  task automatic test_starvation();
    logic owners [4];
    int nseen, done_at;
    logic md;
    apply_reset();
    nseen   = 0;
    done_at = -1;
    for (int c = 0; c < 300 && nseen < 4; c++) begin
      md = 1'b0;
      if (bus.m_wrt === 1'b1) begin
        owners[nseen] = bus.owner;
        nseen++;
        done_at = cyc + 3;
      end
      if (cyc == done_at) md = 1'b1;
      tick(1'b1, 16'($urandom), !bus.busy1, 16'($urandom), md, 16'($urandom));
    end
    n_tests++;
    if (nseen != 4) begin
      n_fail++;
      $display("FAIL starve_timeout: got %0d grants expected 4", nseen);
    end
    for (int i = 0; i < nseen; i++) begin
      n_tests++;
      if (owners[i] !== logic'(i % 2)) begin
        n_fail++;
        $display("FAIL starve_order[%0d]: got %b expected %0d", i, owners[i], i % 2);
      end
    end
    n_tests++;
    if ({bus.ovr0, bus.ovr1} !== 2'b10) begin
      n_fail++;
      $display("FAIL starve_ovr: got %b%b expected 10", bus.ovr0, bus.ovr1);
    end
  endtask

  task automatic test_overwrite();
    int done_at, n_d1, n_w1;
    logic [15:0] cmd_seen;
    logic md;
    apply_reset();
    tick(1'b1, 16'h0AAA, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1);
    tick(1'b0, 16'h0, 1'b1, 16'h1111, 1'b0, 16'h0);
    tick(1'b0, 16'h0, 1'b1, 16'h2222, 1'b0, 16'h0);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0001);
    done_at  = -1;
    n_d1     = 0;
    n_w1     = 0;
    cmd_seen = '0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done1 === 1'b1) n_d1++;
      if (bus.m_wrt === 1'b1) begin
        done_at = cyc + 2;
        if (bus.owner === 1'b1) begin
          n_w1++;
          cmd_seen = bus.m_cmd;
        end
      end
      md = (cyc == done_at);
      tick(1'b0, 16'h0, 1'b0, 16'h0, md, 16'h00EE);
    end
    n_tests++;
    if (cmd_seen !== 16'h2222 || n_w1 != 1) begin
      n_fail++;
      $display("FAIL ovr_cmd: got %h x%0d expected 2222 x1", cmd_seen, n_w1);
    end
    n_tests++;
    if ({bus.ovr0, bus.ovr1} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovr_flag: got %b%b expected 01", bus.ovr0, bus.ovr1);
    end
    n_tests++;
    if (n_d1 != 1) begin
      n_fail++;
      $display("FAIL ovr_done1_count: got %0d expected 1", n_d1);
    end
  endtask

  task automatic test_setclear();
    int done_at, n_d0, nw, busy_bad;
    logic [15:0] cmds [2];
    logic md;
    apply_reset();
    tick(1'b1, 16'h0C01, 1'b0, 16'h0, 1'b0, 16'h0);
    tick(1'b1, 16'h0C02, 1'b0, 16'h0, 1'b0, 16'h0);
    done_at  = -1;
    n_d0     = 0;
    nw       = 0;
    busy_bad = 0;
    cmds[0]  = '0;
    cmds[1]  = '0;
    for (int c = 0; c < 60 && n_d0 < 2; c++) begin
      if (bus.done0 === 1'b1) n_d0++;
      if (n_d0 < 2 && bus.busy0 !== 1'b1) busy_bad++;
      if (bus.m_wrt === 1'b1) begin
        if (nw < 2) cmds[nw] = bus.m_cmd;
        nw++;
        done_at = cyc + 2;
      end
      md = (cyc == done_at);
      if (n_d0 < 2) tick(1'b0, 16'h0, 1'b0, 16'h0, md, 16'h0);
    end
    n_tests++;
    if (n_d0 != 2 || nw != 2 || cmds[0] !== 16'h0C01 || cmds[1] !== 16'h0C02) begin
      n_fail++;
      $display("FAIL setclear_txns: got done=%0d wrt=%0d cmds %h %h expected 2 2 0c01 0c02",
               n_d0, nw, cmds[0], cmds[1]);
    end
    n_tests++;
    if (busy_bad != 0 || bus.busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL setclear_busy: got %0d low cycles, final %b expected 0, final 0",
               busy_bad, bus.busy0);
    end
    n_tests++;
    if (bus.ovr0 !== 1'b0) begin
      n_fail++;
      $display("FAIL setclear_ovr: got %b expected 0", bus.ovr0);
    end
  endtask

  task automatic test_reset_mid_busy();
    int n_d;
    apply_reset();
    tick(1'b1, 16'h5555, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (outs() !== 40'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h expected %h", outs(), 40'h0);
    end
    bus.m_done = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    rst_n = 1'b1;
    n_d = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.m_wrt !== 1'b0) n_d++;
      idle(1);
    end
    n_tests++;
    if (n_d != 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d active cycles expected 0", n_d);
    end
    tick(1'b0, 16'h0, 1'b1, 16'h7777, 1'b0, 16'h0);
    idle(1);
    n_tests++;
    if ({bus.m_wrt, bus.owner, bus.m_cmd} !== {1'b1, 1'b1, 16'h7777}) begin
      n_fail++;
      $display("FAIL rst_after_issue: got %b/%b/%h expected 1/1/7777",
               bus.m_wrt, bus.owner, bus.m_cmd);
    end
    idle(2);
    tick(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'hBEEF);
    n_tests++;
    if ({bus.done0, bus.done1, bus.rd_data} !== {1'b0, 1'b1, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL rst_after_done: got %b/%b/%h expected 0/1/beef",
               bus.done0, bus.done1, bus.rd_data);
    end
  endtask

  task automatic test_random();
    int done_at;
    logic md;
    apply_reset();
    done_at = -1;
    for (int c = 0; c < 1500; c++) begin
      n_tests++;
      if (outs() !== model_outs()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", c, outs(), model_outs());
      end
      md = 1'b0;
      if (e_mwrt) done_at = cyc + int'($urandom_range(1, 6));
      if (cyc == done_at) begin
        md      = 1'b1;
        done_at = -1;
      end else if (!m_infl && $urandom_range(0, 15) == 0) begin
        md = 1'b1;  // spurious completion while nothing is in flight
      end
      tick($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) == 0,
           16'($urandom), md, 16'($urandom));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_starvation();
    test_overwrite();
    test_setclear();
    test_reset_mid_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arb.md
# spi_arb

Round-robin arbiter that shares one 16-bit SPI master (wrt/done handshake) between two requesters: the inertial interface (requester 0) and the A2D interface (requester 1). Sits at the Segway top level between those two interfaces and a single SPI master instance, so the sensors can share one SCLK/MOSI/MISO bus. It buffers one command per requester, issues commands to the master, routes `done` and read data back to the owner, and drives the slave-select routing.

## Interface
- `GUARD`, default 4: idle cycles enforced between consecutive SPI transactions (0 allowed).
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous active-low reset
- `wrt0`, `wrt1`  in  1  one-cycle command strobe from requester 0 / 1
- `cmd0`, `cmd1`  in  16  command word, sampled when the matching `wrt` is high
- `done0`, `done1`  out  1  one-cycle completion pulse to requester 0 / 1
- `rd_data`  out  16  last received word; valid with `doneN`, held until the next completion
- `busy0`, `busy1`  out  1  requester has a pending or in-flight command
- `ovr0`, `ovr1`  out  1  sticky: a pending command was overwritten before it was issued
- `m_wrt`  out  1  one-cycle start strobe to the SPI master
- `m_cmd`  out  16  command to the master, stable from `m_wrt` until `m_done`
- `m_done`  in  1  master completion pulse
- `m_rd_data`  in  16  master receive word, valid with `m_done`
- `owner`  out  1  requester that owns the bus; the top uses it to route `SS_n` and `MISO`

## Operation
- Pending registers: `pendN` and `bufN[15:0]`. `wrtN` sets `pendN` and loads `bufN`.
  - If `wrtN` arrives while `pendN` is already set, `bufN` is overwritten and `ovrN` is set.
  - `ovrN` is cleared only by reset.
- State machine has four states: IDLE, ISSUE, BUSY, GUARD.
- IDLE
  - No pending command: stay in IDLE.
  - Exactly one pending command: grant that requester.
  - Both pending: grant the requester opposite `last`.
  - On a grant: load `owner` and `m_cmd` from the winner's buffer, clear its `pend`, set `last` to the winner, go to ISSUE.
- ISSUE: `m_wrt` is high for exactly this cycle; go to BUSY.
- BUSY: wait for `m_done`. On `m_done`:
  - register `rd_data <= m_rd_data` and pulse `done[owner]` in the next cycle;
  - go to GUARD, or to IDLE if `GUARD == 0`.
- GUARD: count `GUARD` cycles, then go to IDLE. `owner` holds its value through GUARD.
- A new `wrtN` from the current owner during ISSUE, BUSY or GUARD is accepted into `pendN`. It is arbitrated normally in the next IDLE.
- If a `wrtN` and a grant clear of `pendN` occur in the same cycle, the set wins: `pendN` stays 1 with the new `bufN`.
- `busyN = pendN | (owner == N && state != IDLE && doneN not yet pulsed)`.
- A spurious `m_done` outside BUSY is ignored.

## Timing
- Reset values:
  - all outputs 0; `m_cmd`, `rd_data`, `owner` = 0;
  - `last` = 1, so requester 0 wins the first tie;
  - state IDLE, guard counter 0.
- Latency: `wrtN` at cycle t (bus idle) → `pendN` set at t+1 → grant at t+1 → `m_wrt` high at t+2.
- Completion: `m_done` at cycle d → `doneN` and `rd_data` valid at d+1.
- Back-to-back transactions: the next `m_wrt` comes no earlier than d + GUARD + 3.
- Reset asserted mid-transaction: everything returns to reset values immediately, pending commands are lost, no `done` is pulsed. The master is reset by the same `rst_n`.

## Structure
- Shared package: state enum (IDLE/ISSUE/BUSY/GUARD), `REQ_INERT = 1'b0`, `REQ_A2D = 1'b1`.
- No sub-module is needed. The guard counter is a `$clog2(GUARD+1)`-bit down-counter, inline.
- Instantiated in the Segway top with `inert_intf` on port 0 and `A2D_Intf` on port 1. The top muxes `INERT_SS_n`/`A2D_SS_n` by `owner`.

## Test plan
- Single request: `wrt0` with `cmd0 = 16'hA5A5`, `m_done` 20 cycles after `m_wrt` with `m_rd_data = 16'h1234`.
  - Expect `m_wrt` 2 cycles after `wrt0`, `m_cmd = A5A5`, `owner = 0`.
  - Expect `done0` one cycle after `m_done` with `rd_data = 1234`, and no `done1`.
- Simultaneous `wrt0`/`wrt1` after reset:
  - requester 0 is served first, then requester 1;
  - the second `m_wrt` comes exactly `GUARD + 3` cycles after the first `m_done`.
- Starvation check: requester 0 re-requests every cycle while `wrt1` is pending. Expect strict alternation 0,1,0,1 over 4 transactions.
- Overwrite: `wrt1` with `cmd1 = 0x1111`, then `0x2222`, both during a requester-0 transaction.
  - Expect `ovr1 = 1` and the issued `m_cmd = 0x2222`.
  - Expect only one `done1`.
- Same-cycle set/clear: `wrt0` in the grant cycle of requester 0. Expect two requester-0 transactions and `busy0` high until the second `done0`.
- Reset mid-BUSY: drop `rst_n` during BUSY.
  - Outputs go to 0 asynchronously and no `done` follows.
  - After release, a new `wrt1` is served normally.
